vdg_addr_gen: RTL and testbench
===============================

VDG_ADDR_GEN -- requirements
Module: vdg_addr_gen

Interface
REQ-001 Parameter ADDR_W, default 16: video RAM address width.
REQ-002 Parameter MAX_FETCH, default 32: maximum byte fetches accepted per scan line.
REQ-003 Clk  input  1: single system clock, same clock that drives the VDG timing, all logic on rising edge.
REQ-004 Rst  input  1: reset, synchronous, active-high.
REQ-005 DA0  input  1: VDG fetch strobe; each rising transition requests one byte.
REQ-006 HSn  input  1: VDG horizontal sync, active low; a falling transition marks end of line.
REQ-007 FSn  input  1: VDG field sync, active low; a falling transition marks start of field.
REQ-008 VMode  input  3: SAM-style display mode selecting the row repeat count.
REQ-009 VBase  input  7: display base; start address = VBase * 512.
REQ-010 Addr  output  ADDR_W: registered video RAM address of the current fetch.
REQ-011 AddrStb  output  1: one-cycle pulse, Addr valid for a RAM read.
REQ-012 RowIdx  output  4: current repeat index within the display row (0..repeat-1).
REQ-013 FetchErr  output  1: sticky flag, a line exceeded MAX_FETCH fetches; cleared at field start.

Function
REQ-014 DA0, HSn and FSn are each registered once; an edge is a sampled value differing from the previous sample, in the stated direction.
REQ-015 Latency: AddrStb asserts in the cycle after DA0 is first sampled high; Addr holds the fetch address from that cycle until the next strobe.
REQ-016 After each strobe, the current-address counter increments by 1, wrapping modulo 2^ADDR_W.
REQ-017 The repeat count is latched from VMode only at an FSn falling edge, using 0:12, 1:3, 2:3, 3:2, 4:2, 5:1, 6:1, 7:1. A VMode change mid-field has no effect until the next field.
REQ-018 At an FSn falling edge: row-start and current address = VBase*512; RowIdx = 0; fetch count = 0; FetchErr = 0.
REQ-019 At an HSn falling edge with RowIdx < repeat-1, the block performs all of the following:
- current address reloads to row-start;
- RowIdx increments;
- fetch count clears.
REQ-020 At an HSn falling edge with RowIdx = repeat-1, the block performs all of the following:
- row-start and current address take the current address value (next row begins);
- RowIdx = 0;
- fetch count clears.
REQ-021 An HSn falling edge with zero fetches in the line is still counted as a line per REQ-019/020.
REQ-022 Fetch count saturates at MAX_FETCH. A DA0 edge at saturation sets FetchErr, produces no strobe and no increment.
REQ-023 Simultaneous events, FSn vs HSn: if FSn falls in the same cycle as HSn, REQ-018 applies and HSn is ignored.
REQ-024 Simultaneous events, DA0 vs HSn/FSn: a DA0 rising edge in the same cycle as an HSn or FSn falling edge is discarded, with no strobe.
REQ-025 Edges present on the inputs while Rst is high are not acted upon after release; the edge registers are loaded with the current input values during reset.

Reset
REQ-026 While Rst is high at a clock edge, the following reset values are applied:
- Addr = 0, AddrStb = 0, RowIdx = 0, FetchErr = 0;
- row-start = 0, fetch count = 0;
- repeat count = 12;
- edge registers = current input levels.
REQ-027 Rst asserted mid-line aborts any pending strobe. The first strobe after reset occurs only after a new DA0 rising edge.
REQ-028 Addressing is undefined-free after reset: without an FSn edge, fetches start from address 0 with repeat 12.

Structure
REQ-029 Package vdg_pkg holds the following:
- the mode repeat table as a constant function or array;
- ADDR_W and MAX_FETCH defaults;
- the base shift constant (9).
REQ-030 One sub-module, vdg_edge_det (registered rise/fall detector, instantiated three times), is used; all other logic stays in vdg_addr_gen.

Verification
REQ-031 VBase=7'h02, VMode=0, FSn fall, 32 DA0 pulses, HSn fall, repeated 12 lines -> Addr 0x0400..0x041F on each of the 12 lines; the 13th line starts at 0x0420; RowIdx steps 0..11.
REQ-032 VMode=6, 16 fetches/line, 3 lines -> line starts 0x0400, 0x0410, 0x0420; RowIdx constant 0.
REQ-033 VBase=7'h7F, VMode=6, 1024 lines of 32 fetches -> Addr wraps from 0xFFFF to 0x0000 with no gap.
REQ-034 33 DA0 pulses in one line -> 32 strobes, FetchErr=1 until next FSn fall; DA0 coincident with HSn fall -> no strobe.
REQ-035 Rst pulsed for 1 cycle mid-line at Addr=0x0415 -> next strobe Addr=0x0000, RowIdx=0, no strobe from a DA0 high level held through reset.
REQ-036 VMode changed 0->3 mid-field -> repeat remains 12 until next FSn fall, then 2.

Source files
------------

// File: rtl/vdg_pkg.sv
// vdg_pkg -- shared definitions for the VDG video address generator.
//   VDG_ADDR_W / VDG_MAX_FETCH : default address width and per-line fetch limit
//   VDG_BASE_SHIFT             : VBase is scaled by 2^VDG_BASE_SHIFT (512-byte pages)
//   VDG_RESET_REPEAT           : row repeat count used before the first field start
//   vdg_event_e                : resolved per-cycle event after edge priority
//   mode_repeat()              : SAM display mode -> scan lines per display row
package vdg_pkg;

  localparam int VDG_ADDR_W     = 16;
  localparam int VDG_MAX_FETCH  = 32;
  localparam int VDG_BASE_SHIFT = 9;

  localparam logic [3:0] VDG_RESET_REPEAT = 4'd12;

  typedef enum logic [1:0] {
    EV_NONE  = 2'd0,
    EV_FIELD = 2'd1,
    EV_LINE  = 2'd2,
    EV_FETCH = 2'd3
  } vdg_event_e;

  function automatic logic [3:0] mode_repeat(input logic [2:0] mode);
    logic [3:0] rep;
    case (mode)
      3'd0:             rep = 4'd12;
      3'd1, 3'd2:       rep = 4'd3;
      3'd3, 3'd4:       rep = 4'd2;
      3'd5, 3'd6, 3'd7: rep = 4'd1;
      default:          rep = 4'd1;
    endcase
    return rep;
  endfunction

endpackage

// File: rtl/vdg_edge_det.sv
// vdg_edge_det -- single-register edge detector.
//   Clk   : system clock
//   Rst   : synchronous active-high reset
//   Din   : level to watch
//   Pulse : high for the cycle in which Din differs from its previous sample
//           in the selected direction (rising, or falling when FALLING = 1)
// During reset the history register tracks the live input, so a level that is
// already present when reset releases is never reported as an edge.
module vdg_edge_det #(
  parameter bit FALLING = 1'b0
) (
  input  logic Clk,
  input  logic Rst,
  input  logic Din,
  output logic Pulse
);

  logic prev_r;

  // Keep the level seen at the previous clock edge.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      prev_r <= Din;
    end else begin
      prev_r <= Din;
    end
  end

  assign Pulse = FALLING ? (prev_r & ~Din) : (Din & ~prev_r);

endmodule

// File: rtl/vdg_addr_gen.sv
// vdg_addr_gen -- video RAM address generator driven by VDG timing strobes.
//   Clk      : system clock (also clocks the VDG), rising edge
//   Rst      : synchronous active-high reset
//   DA0      : fetch strobe, each rising edge requests one byte
//   HSn      : horizontal sync, falling edge ends a scan line
//   FSn      : field sync, falling edge starts a field
//   VMode    : display mode, picks scan lines per display row (latched at field start)
//   VBase    : display base, field start address = VBase * 512
//   Addr     : address of the most recent fetch, held until the next fetch
//   AddrStb  : one-cycle pulse marking a new Addr
//   RowIdx   : scan line index within the current display row
//   FetchErr : sticky, a line asked for more than MAX_FETCH bytes
module vdg_addr_gen
  import vdg_pkg::*;
#(
  parameter int ADDR_W    = VDG_ADDR_W,
  parameter int MAX_FETCH = VDG_MAX_FETCH
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              DA0,
  input  logic              HSn,
  input  logic              FSn,
  input  logic [2:0]        VMode,
  input  logic [6:0]        VBase,
  output logic [ADDR_W-1:0] Addr,
  output logic              AddrStb,
  output logic [3:0]        RowIdx,
  output logic              FetchErr
);

  localparam int              CNT_W   = $clog2(MAX_FETCH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_FETCH);

  logic              da_rise_s;
  logic              hs_fall_s;
  logic              fs_fall_s;
  vdg_event_e        event_s;
  logic [ADDR_W-1:0] base_s;
  logic              line_wrap_s;
  logic              fetch_full_s;

  logic [ADDR_W-1:0] addr_r;
  logic              stb_r;
  logic [3:0]        row_idx_r;
  logic              err_r;
  logic [ADDR_W-1:0] row_start_r;
  logic [ADDR_W-1:0] cur_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [3:0]        rep_r;

  vdg_edge_det #(.FALLING(1'b0)) u_da_det (.Clk(Clk), .Rst(Rst), .Din(DA0), .Pulse(da_rise_s));
  vdg_edge_det #(.FALLING(1'b1)) u_hs_det (.Clk(Clk), .Rst(Rst), .Din(HSn), .Pulse(hs_fall_s));
  vdg_edge_det #(.FALLING(1'b1)) u_fs_det (.Clk(Clk), .Rst(Rst), .Din(FSn), .Pulse(fs_fall_s));

  assign base_s       = ADDR_W'(VBase) << VDG_BASE_SHIFT;
  assign line_wrap_s  = (row_idx_r == (rep_r - 4'd1));
  assign fetch_full_s = (cnt_r == CNT_MAX);

  // Coincident edges: field start swallows a line end, and either one swallows a fetch.
  always_comb begin
    event_s = EV_NONE;
    if (fs_fall_s) begin
      event_s = EV_FIELD;
    end else if (hs_fall_s) begin
      event_s = EV_LINE;
    end else if (da_rise_s) begin
      event_s = EV_FETCH;
    end else begin
      event_s = EV_NONE;
    end
  end

  // Address, row-repeat and fetch-count bookkeeping for the resolved event.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      addr_r      <= {ADDR_W{1'b0}};
      stb_r       <= 1'b0;
      row_idx_r   <= 4'd0;
      err_r       <= 1'b0;
      row_start_r <= {ADDR_W{1'b0}};
      cur_r       <= {ADDR_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      rep_r       <= VDG_RESET_REPEAT;
    end else begin
      stb_r <= 1'b0;
      case (event_s)
        EV_FIELD: begin
          rep_r       <= mode_repeat(VMode);
          row_start_r <= base_s;
          cur_r       <= base_s;
          row_idx_r   <= 4'd0;
          cnt_r       <= {CNT_W{1'b0}};
          err_r       <= 1'b0;
        end
        EV_LINE: begin
          if (line_wrap_s) begin
            // Last repeat of this row: the next row starts where fetching stopped.
            row_start_r <= cur_r;
            row_idx_r   <= 4'd0;
          end else begin
            // Repeat the same display row on the next scan line.
            cur_r     <= row_start_r;
            row_idx_r <= row_idx_r + 4'd1;
          end
          cnt_r <= {CNT_W{1'b0}};
        end
        EV_FETCH: begin
          if (fetch_full_s) begin
            err_r <= 1'b1;
          end else begin
            stb_r  <= 1'b1;
            addr_r <= cur_r;
            cur_r  <= cur_r + ADDR_W'(1);
            cnt_r  <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          stb_r <= 1'b0;
        end
      endcase
    end
  end

  assign Addr     = addr_r;
  assign AddrStb  = stb_r;
  assign RowIdx   = row_idx_r;
  assign FetchErr = err_r;

endmodule

// File: tb/tb_vdg_addr_gen.sv
// tb_vdg_addr_gen -- randomized and directed bench for vdg_addr_gen with a
// behavioural reference model checked on every clock.
module tb_vdg_addr_gen;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        DA0;
  logic        HSn;
  logic        FSn;
  logic [2:0]  VMode;
  logic [6:0]  VBase;
  logic [15:0] Addr;
  logic        AddrStb;
  logic [3:0]  RowIdx;
  logic        FetchErr;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state, described in terms of the display, not the RTL.
  int rep_tab [8] = '{12, 3, 3, 2, 2, 1, 1, 1};
  int m_addr, m_cur, m_start, m_row, m_rep, m_cnt;
  bit m_stb, m_err;
  bit m_da_p, m_hs_p, m_fs_p;

  int log_addr[$];
  int log_row[$];

  vdg_addr_gen dut (
    .Clk(Clk), .Rst(Rst), .DA0(DA0), .HSn(HSn), .FSn(FSn),
    .VMode(VMode), .VBase(VBase),
    .Addr(Addr), .AddrStb(AddrStb), .RowIdx(RowIdx), .FetchErr(FetchErr)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply the display rules for one clock edge with the given pin levels.
  task automatic model_step(input bit rst, input bit da, input bit hs, input bit fs,
                            input int vm, input int vb);
    bit da_rise, hs_fall, fs_fall;
    da_rise = da && !m_da_p;
    hs_fall = !hs && m_hs_p;
    fs_fall = !fs && m_fs_p;
    m_da_p = da; m_hs_p = hs; m_fs_p = fs;
    m_stb = 1'b0;
    if (rst) begin
      m_addr = 0; m_row = 0; m_err = 1'b0; m_start = 0; m_cur = 0; m_cnt = 0; m_rep = 12;
    end else if (fs_fall) begin
      m_rep = rep_tab[vm]; m_start = vb * 512; m_cur = m_start;
      m_row = 0; m_cnt = 0; m_err = 1'b0;
    end else if (hs_fall) begin
      if (m_row == m_rep - 1) begin
        m_start = m_cur; m_row = 0;
      end else begin
        m_cur = m_start; m_row = m_row + 1;
      end
      m_cnt = 0;
    end else if (da_rise) begin
      if (m_cnt == 32) begin
        m_err = 1'b1;
      end else begin
        m_stb = 1'b1; m_addr = m_cur; m_cur = (m_cur + 1) % 65536; m_cnt = m_cnt + 1;
      end
    end
  endtask

  // Every clock: outputs against the model, and log each strobe for directed checks.
  always @(posedge Clk) begin
    #1;
    check("AddrStb", {31'd0, AddrStb}, {31'd0, m_stb});
    check("Addr", {16'd0, Addr}, m_addr);
    check("RowIdx", {28'd0, RowIdx}, m_row);
    check("FetchErr", {31'd0, FetchErr}, {31'd0, m_err});
    if (AddrStb === 1'b1) begin
      log_addr.push_back(int'(Addr));
      log_row.push_back(int'(RowIdx));
    end
  end

  task automatic cyc(input logic rst, input logic da, input logic hs, input logic fs);
    @(negedge Clk);
    Rst = rst; DA0 = da; HSn = hs; FSn = fs;
    model_step(rst, da, hs, fs, int'(VMode), int'(VBase));
    @(posedge Clk);
    #2;
  endtask

  task automatic fetch();
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic hline();
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic field();
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_row.delete();
  endtask

  initial begin
    Rst = 1'b1; DA0 = 1'b0; HSn = 1'b1; FSn = 1'b1; VMode = 3'd0; VBase = 7'd0;
    model_step(1'b1, 1'b0, 1'b1, 1'b1, 0, 0);
    repeat (3) cyc(1'b1, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    check("reset_addr", {16'd0, Addr}, 32'd0);
    check("reset_stb", {31'd0, AddrStb}, 32'd0);
    check("reset_row", {28'd0, RowIdx}, 32'd0);

    // No field start yet: fetching begins at 0 and repeat count is 12.
    clear_log();
    fetch(); fetch();
    check("nofield_a0", log_addr[0], 32'h0000);
    check("nofield_a1", log_addr[1], 32'h0001);
    hline();
    check("nofield_row", {28'd0, RowIdx}, 32'd1);

    // Mode 0: twelve identical lines, then the next row.
    VBase = 7'h02; VMode = 3'd0;
    field();
    clear_log();
    for (int l = 0; l < 13; l++) begin
      for (int f = 0; f < 32; f++) fetch();
      hline();
    end
    check("m0_count", log_addr.size(), 32'd416);
    for (int l = 0; l < 12; l++) begin
      check("m0_first", log_addr[l * 32], 32'h0400);
      check("m0_last", log_addr[l * 32 + 31], 32'h041F);
      check("m0_row", log_row[l * 32], l);
    end
    check("m0_next_row", log_addr[384], 32'h0420);
    check("m0_next_idx", log_row[384], 32'd0);

    // Mode change mid-field keeps repeat 12 until the next field.
    VMode = 3'd3;
    repeat (10) hline();
    check("vm_hold_row11", {28'd0, RowIdx}, 32'd11);
    hline();
    check("vm_hold_wrap", {28'd0, RowIdx}, 32'd0);
    field();
    hline();
    check("vm3_row1", {28'd0, RowIdx}, 32'd1);
    hline();
    check("vm3_row0", {28'd0, RowIdx}, 32'd0);

    // Mode 6: one line per row, 16 fetches per line.
    VMode = 3'd6; VBase = 7'h02;
    field();
    clear_log();
    for (int l = 0; l < 3; l++) begin
      for (int f = 0; f < 16; f++) fetch();
      hline();
    end
    check("m6_l0", log_addr[0], 32'h0400);
    check("m6_l1", log_addr[16], 32'h0410);
    check("m6_l2", log_addr[32], 32'h0420);
    check("m6_row", log_row[40], 32'd0);

    // Overflow: 33 requests give 32 strobes and a sticky error.
    field();
    clear_log();
    repeat (33) fetch();
    check("ovf_count", log_addr.size(), 32'd32);
    check("ovf_err", {31'd0, FetchErr}, 32'd1);
    hline();
    check("ovf_err_sticky", {31'd0, FetchErr}, 32'd1);
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    check("coinc_nostb", log_addr.size(), 32'd32);
    fetch();
    check("coinc_after", log_addr[32], 32'h0420);
    field();
    check("ovf_err_clr", {31'd0, FetchErr}, 32'd0);

    // Reset mid-line with DA0 held high through it.
    clear_log();
    repeat (22) fetch();
    check("rst_pre", log_addr[21], 32'h0415);
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    check("rst_nostb", log_addr.size(), 32'd22);
    fetch();
    check("rst_addr", log_addr[22], 32'h0000);
    check("rst_row", log_row[22], 32'd0);

    // Top of memory: the address wraps to 0 with no gap.
    VBase = 7'h7F; VMode = 3'd6;
    field();
    clear_log();
    for (int l = 0; l < 17; l++) begin
      for (int f = 0; f < 32; f++) fetch();
      hline();
    end
    check("wrap_top", log_addr[511], 32'hFFFF);
    check("wrap_zero", log_addr[512], 32'h0000);
    begin
      int gaps;
      gaps = 0;
      for (int i = 1; i < log_addr.size(); i++)
        if (log_addr[i] != (log_addr[i - 1] + 1) % 65536) gaps++;
      check("wrap_gaps", gaps, 32'd0);
    end

    // Random traffic, including coincident edges, resets and mode/base changes.
    for (int i = 0; i < 4000; i++) begin
      logic r, d, h, f;
      r = ($urandom_range(0, 299) == 0);
      d = ($urandom_range(0, 9) == 0) ? DA0 : ~DA0;
      h = ($urandom_range(0, 79) != 0);
      f = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 99) == 0) VMode = 3'($urandom);
      if ($urandom_range(0, 99) == 0) VBase = 7'($urandom);
      cyc(r, d, h, f);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
